// File: rtl/delay_meter.sv
// -----------------------------------------------------------------------------
// delay_meter
//
// Measures the number of clock cycles between a start pulse and a stop pulse.
// Used for loopback calibration: start marks a sync entering a delay path and
// stop marks it leaving. Every completed measurement is reported with a
// one-cycle strobe. A measurement that never sees its stop is aborted after
// TIMEOUT_CYCLES. Running min/max statistics and a sticky overrun flag are
// kept until cleared.
//
// Parameters
//   COUNT_WIDTH    width of the cycle counter and all result outputs
//   TIMEOUT_CYCLES abort when the counter reaches this value (< 2**COUNT_WIDTH)
//   STOP_EDGE      0: stop is a level-high pulse, 1: stop acts on rising edge
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   i_en           arm enable; start is ignored in IDLE while low
//   i_clr          clears min/max/overrun statistics (one cycle)
//   i_start        start pulse
//   i_stop         stop pulse
//   o_delay_out    last measured latency in cycles
//   o_data_valid   one-cycle strobe: o_delay_out was just updated
//   o_timeout      one-cycle strobe: measurement aborted
//   o_busy         high while a measurement is running
//   o_min_delay    smallest valid measurement since clear (all ones if none)
//   o_max_delay    largest valid measurement since clear (zero if none)
//   o_overrun      sticky: start seen while a measurement was running
//   o_dbg_state    current FSM state (0 = IDLE, 1 = COUNT)
//
// Handshake: there is no backpressure. o_data_valid and o_timeout are
// single-cycle strobes that are never high together; a consumer must sample
// o_delay_out on the cycle o_data_valid is high or simply read it later, as
// it holds its value until the next valid measurement.
// -----------------------------------------------------------------------------
module delay_meter #(
    parameter int COUNT_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit STOP_EDGE      = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic                   i_start,
    input  logic                   i_stop,
    output logic [COUNT_WIDTH-1:0] o_delay_out,
    output logic                   o_data_valid,
    output logic                   o_timeout,
    output logic                   o_busy,
    output logic [COUNT_WIDTH-1:0] o_min_delay,
    output logic [COUNT_WIDTH-1:0] o_max_delay,
    output logic                   o_overrun,
    output logic                   o_dbg_state
);

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                   r_state;
    logic [COUNT_WIDTH-1:0]   r_counter;
    logic                     r_stop_d;
    logic [COUNT_WIDTH-1:0]   r_delay;
    logic                     r_data_valid;
    logic                     r_timeout;
    logic [COUNT_WIDTH-1:0]   r_min;
    logic [COUNT_WIDTH-1:0]   r_max;
    logic                     r_overrun;

    // -------------------------------------------------------------------------
    // Next-state / next-value wires
    // -------------------------------------------------------------------------
    logic                     w_stop_evt;
    state_t                   w_state_nxt;
    logic [COUNT_WIDTH-1:0]   w_counter_nxt;
    logic                     w_result_ld;
    logic [COUNT_WIDTH-1:0]   w_result_val;
    logic                     w_timeout_nxt;
    logic                     w_overrun_set;
    logic [COUNT_WIDTH-1:0]   w_min_base;
    logic [COUNT_WIDTH-1:0]   w_max_base;
    logic [COUNT_WIDTH-1:0]   w_min_nxt;
    logic [COUNT_WIDTH-1:0]   w_max_nxt;
    logic                     w_overrun_nxt;

    // In edge mode a stop that stays high only counts on its first cycle.
    // r_stop_d is always tracked so the level mode does not leave it unused.
    assign w_stop_evt = i_stop & ~(STOP_EDGE ? r_stop_d : 1'b0);

    // -------------------------------------------------------------------------
    // FSM next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_result_ld   = 1'b0;
        w_result_val  = '0;
        w_timeout_nxt = 1'b0;
        w_overrun_set = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start && i_en) begin
                    if (w_stop_evt) begin
                        // Start and stop on the same cycle: zero-latency path.
                        w_result_ld  = 1'b1;
                        w_result_val = '0;
                    end else begin
                        // Counter reads 1 on the first cycle after start so
                        // that it equals the elapsed cycles when stop arrives.
                        w_state_nxt   = S_COUNT;
                        w_counter_nxt = CNT_ONE;
                    end
                end
            end

            S_COUNT: begin
                // Any start while counting (enable does not matter) is a
                // protocol overrun, including one coinciding with stop.
                w_overrun_set = i_start;
                if (w_stop_evt) begin
                    // Stop takes priority over a timeout on the same cycle.
                    w_result_ld   = 1'b1;
                    w_result_val  = r_counter;
                    w_state_nxt   = S_IDLE;
                    w_counter_nxt = '0;
                end else if (r_counter == TIMEOUT_VAL) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                    w_counter_nxt = '0;
                end else begin
                    w_counter_nxt = r_counter + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_counter_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Statistics next values
    // -------------------------------------------------------------------------
    // Clear is applied to the base first; a result arriving on the same cycle
    // is then folded into the cleared values, leaving min = max = result.
    always_comb begin
        w_min_base = i_clr ? '1 : r_min;
        w_max_base = i_clr ? '0 : r_max;
        w_min_nxt  = w_min_base;
        w_max_nxt  = w_max_base;
        if (w_result_ld) begin
            if (w_result_val < w_min_base) begin
                w_min_nxt = w_result_val;
            end
            if (w_result_val > w_max_base) begin
                w_max_nxt = w_result_val;
            end
        end
        // A new overrun on the clear cycle survives the clear.
        w_overrun_nxt = w_overrun_set | (r_overrun & ~i_clr);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_counter    <= '0;
            r_stop_d     <= 1'b0;
            r_delay      <= '0;
            r_data_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_min        <= '1;
            r_max        <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_counter    <= w_counter_nxt;
            r_stop_d     <= i_stop;
            r_data_valid <= w_result_ld;
            r_timeout    <= w_timeout_nxt;
            r_min        <= w_min_nxt;
            r_max        <= w_max_nxt;
            r_overrun    <= w_overrun_nxt;
            if (w_result_ld) begin
                r_delay <= w_result_val;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_delay_out  = r_delay;
    assign o_data_valid = r_data_valid;
    assign o_timeout    = r_timeout;
    assign o_busy       = (r_state == S_COUNT);
    assign o_min_delay  = r_min;
    assign o_max_delay  = r_max;
    assign o_overrun    = r_overrun;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_delay_meter.sv
// -----------------------------------------------------------------------------
// tb_delay_meter
//
// Two instances share all inputs: index 0 uses level stop, index 1 uses
// rising-edge stop. Both use a 16-cycle timeout. A timestamp-based reference
// model (start time vs. stop time) predicts every output after every clock.
// -----------------------------------------------------------------------------
module tb_delay_meter;

  localparam int W  = 32;
  localparam int TO = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst, en, clr, start, stop;

  logic [W-1:0] delay_out [2];
  logic         dv        [2];
  logic         tmo       [2];
  logic         busy      [2];
  logic [W-1:0] min_d     [2];
  logic [W-1:0] max_d     [2];
  logic         ovr       [2];
  logic         dbg       [2];

  always #5 clk = ~clk;

  delay_meter #(.COUNT_WIDTH(W), .TIMEOUT_CYCLES(TO), .STOP_EDGE(1'b0)) u_dut_lvl (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_start(start), .i_stop(stop),
    .o_delay_out(delay_out[0]), .o_data_valid(dv[0]), .o_timeout(tmo[0]),
    .o_busy(busy[0]), .o_min_delay(min_d[0]), .o_max_delay(max_d[0]),
    .o_overrun(ovr[0]), .o_dbg_state(dbg[0])
  );

  delay_meter #(.COUNT_WIDTH(W), .TIMEOUT_CYCLES(TO), .STOP_EDGE(1'b1)) u_dut_edge (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_start(start), .i_stop(stop),
    .o_delay_out(delay_out[1]), .o_data_valid(dv[1]), .o_timeout(tmo[1]),
    .o_busy(busy[1]), .o_min_delay(min_d[1]), .o_max_delay(max_d[1]),
    .o_overrun(ovr[1]), .o_dbg_state(dbg[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: measurements are timestamp differences
  // ---------------------------------------------------------------------------
  int           cyc = 0;
  logic         m_busy   [2];
  int           m_t0     [2];
  logic         m_stop_d [2];
  logic [W-1:0] m_delay  [2];
  logic         m_dv     [2];
  logic         m_to     [2];
  logic [W-1:0] m_min    [2];
  logic [W-1:0] m_max    [2];
  logic         m_ovr    [2];

  task automatic model_step(input int k, input logic r, input logic e, input logic c,
                            input logic s, input logic p);
    logic         evt;
    logic         was_busy;
    logic         have;
    int           el;
    logic [W-1:0] n;
    if (r) begin
      m_busy[k] = 1'b0;  m_stop_d[k] = 1'b0; m_delay[k] = '0;
      m_dv[k]   = 1'b0;  m_to[k]     = 1'b0;
      m_min[k]  = '1;    m_max[k]    = '0;   m_ovr[k]   = 1'b0;
      return;
    end
    evt         = (k == 1) ? (p && !m_stop_d[k]) : p;
    m_stop_d[k] = p;
    m_dv[k]     = 1'b0;
    m_to[k]     = 1'b0;
    have        = 1'b0;
    n           = '0;
    was_busy    = m_busy[k];
    if (!was_busy) begin
      if (s && e) begin
        if (evt) begin
          have = 1'b1;
        end else begin
          m_busy[k] = 1'b1;
          m_t0[k]   = cyc;
        end
      end
    end else begin
      el = cyc - m_t0[k];
      if (evt) begin
        have      = 1'b1;
        n         = W'(el);
        m_busy[k] = 1'b0;
      end else if (el == TO) begin
        m_to[k]   = 1'b1;
        m_busy[k] = 1'b0;
      end
    end
    if (c) begin
      m_min[k] = '1;
      m_max[k] = '0;
      m_ovr[k] = 1'b0;
    end
    if (was_busy && s) m_ovr[k] = 1'b1;
    if (have) begin
      m_dv[k]    = 1'b1;
      m_delay[k] = n;
      if (n < m_min[k]) m_min[k] = n;
      if (n > m_max[k]) m_max[k] = n;
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model%0d.busy", k),  W'(busy[k]), W'(m_busy[k]));
      chk($sformatf("model%0d.dv", k),    W'(dv[k]),   W'(m_dv[k]));
      chk($sformatf("model%0d.to", k),    W'(tmo[k]),  W'(m_to[k]));
      chk($sformatf("model%0d.delay", k), delay_out[k], m_delay[k]);
      chk($sformatf("model%0d.min", k),   min_d[k],    m_min[k]);
      chk($sformatf("model%0d.max", k),   max_d[k],    m_max[k]);
      chk($sformatf("model%0d.ovr", k),   W'(ovr[k]),  W'(m_ovr[k]));
      chk($sformatf("model%0d.excl", k),  W'(dv[k] & tmo[k]), '0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, advance model, compare after the edge
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic e, input logic c,
                      input logic s, input logic p);
    rst = r; en = e; clr = c; start = s; stop = p;
    @(posedge clk);
    model_step(0, r, e, c, s, p);
    model_step(1, r, e, c, s, p);
    cyc++;
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // start, n-1 quiet cycles (optional extra start at offset extra), then stop
  task automatic measure(input int n, input logic clr_on_stop, input int extra);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < n; i++) step(1'b0, 1'b1, 1'b0, (i == extra), 1'b0);
    step(1'b0, 1'b1, clr_on_stop, 1'b0, 1'b1);
  endtask

  task automatic expect_lvl(input string tag, input logic b, input logic d,
                            input logic t, input logic [W-1:0] dl);
    chk({tag, ".busy"},  W'(busy[0]), W'(b));
    chk({tag, ".dv"},    W'(dv[0]),   W'(d));
    chk({tag, ".to"},    W'(tmo[0]),  W'(t));
    chk({tag, ".delay"}, delay_out[0], dl);
  endtask

  task automatic expect_stats(input string tag, input int k, input logic [W-1:0] mn,
                              input logic [W-1:0] mx, input logic ov);
    chk({tag, ".min"}, min_d[k], mn);
    chk({tag, ".max"}, max_d[k], mx);
    chk({tag, ".ovr"}, W'(ovr[k]), W'(ov));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (level-stop instance)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         en;
    logic         clr;
    logic         start;
    logic         stop;
    logic         exp_busy;
    logic         exp_dv;
    logic         exp_to;
    logic [W-1:0] exp_delay;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // start@0 stop@5, start&stop together, lone stop, start with en low
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

    rst = 1'b1; en = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0;

    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_lvl("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    expect_stats("reset", 0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    idle(2);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      step(1'b0, vecs[i].en, vecs[i].clr, vecs[i].start, vecs[i].stop);
      expect_lvl($sformatf("vec%0d", i), vecs[i].exp_busy, vecs[i].exp_dv,
                 vecs[i].exp_to, vecs[i].exp_delay);
    end
    expect_stats("after_vec", 0, 32'd0, 32'd5, 1'b0);

    // Timeout: no stop for TO cycles
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      idle(1);
      if (k < TO) expect_lvl($sformatf("tmo_run%0d", k), 1'b1, 1'b0, 1'b0, 32'd0);
      else        expect_lvl("tmo_hit", 1'b0, 1'b0, 1'b1, 32'd0);
    end
    idle(1);
    expect_lvl("tmo_after", 1'b0, 1'b0, 1'b0, 32'd0);
    expect_stats("tmo_stats", 0, 32'd0, 32'd5, 1'b0);

    // Stop on the timeout cycle wins
    measure(TO, 1'b0, -1);
    expect_lvl("tmo_edge", 1'b0, 1'b1, 1'b0, 32'd16);
    idle(1);

    // Statistics: 7, 3, 12, clear, 9, then clear coincident with 4
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_stats("clr0", 0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    measure(7, 1'b0, -1);  idle(1);
    measure(3, 1'b0, -1);  idle(1);
    measure(12, 1'b0, -1);
    expect_lvl("m12", 1'b0, 1'b1, 1'b0, 32'd12);
    expect_stats("stats_3_12", 0, 32'd3, 32'd12, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_stats("clr1", 0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    measure(9, 1'b0, -1);
    expect_stats("stats_9", 0, 32'd9, 32'd9, 1'b0);
    idle(1);
    measure(4, 1'b1, -1);
    expect_stats("clr_with_4", 0, 32'd4, 32'd4, 1'b0);
    idle(1);

    // Overrun: second start at +2 of a 10-cycle measurement
    measure(10, 1'b0, 2);
    expect_lvl("ovr_m10", 1'b0, 1'b1, 1'b0, 32'd10);
    chk("ovr_set", W'(ovr[0]), 32'd1);
    idle(3);
    chk("ovr_sticky", W'(ovr[0]), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovr_clr", W'(ovr[0]), 32'd0);

    // Start coincident with stop: overrun, no re-arm
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_lvl("stop_start", 1'b0, 1'b1, 1'b0, 32'd1);
    chk("stop_start_ovr", W'(ovr[0]), 32'd1);
    idle(1);
    chk("no_rearm", W'(busy[0]), 32'd0);

    // Reset in the middle of a measurement
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_lvl("mid_rst", 1'b0, 1'b0, 1'b0, 32'd0);
    expect_stats("mid_rst", 0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_lvl("post_rst_stop", 1'b0, 1'b0, 1'b0, 32'd0);

    // Edge mode: stop held high for three cycles gives one event
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("edge_dv1", W'(dv[1]), 32'd1);
    chk("edge_d1", delay_out[1], 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("edge_hold2", W'(dv[1]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("edge_hold3", W'(dv[1]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("edge_arm_held", W'(busy[1]), 32'd1);
    chk("lvl_zero_held", W'(dv[0]), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("edge_dv2", W'(dv[1]), 32'd1);
    chk("edge_d2", delay_out[1], 32'd2);
    chk("edge_stats_min", min_d[1], 32'd1);
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
